instr_fetch: RTL and testbench



---
 rtl/cpu_fetch_pkg.sv | 20 ++
 rtl/instr_len_decode.sv | 19 +
 rtl/instr_fetch.sv | 142 ++++++++++++++
 tb/tb_instr_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction size codes
// and the position of the length field inside an opcode byte.
package cpu_fetch_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_OP  = 3'd0;
    localparam logic [STATE_W-1:0] S_B1  = 3'd1;
    localparam logic [STATE_W-1:0] S_B2  = 3'd2;
    localparam logic [STATE_W-1:0] S_B3  = 3'd3;
    localparam logic [STATE_W-1:0] S_OUT = 3'd4;

    localparam logic [1:0] SZ1 = 2'd1;
    localparam logic [1:0] SZ2 = 2'd2;
    localparam logic [1:0] SZ3 = 2'd3;

    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 6;

endpackage

// File: rtl/instr_len_decode.sv
// Opcode length decoder; also used by the decode stage, so it stays purely
// combinational.
module instr_len_decode
    import cpu_fetch_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] size
);

    // Encoding 11 is reserved and treated as a single-byte instruction.
    always_comb begin
        case (opcode[LEN_MSB:LEN_LSB])
            2'b01:   size = SZ2;
            2'b10:   size = SZ3;
            default: size = SZ1;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: reads 1-3 bytes at pc from synchronous byte memory,
// presents the assembled instruction to decode and tells the PC when to move.
module instr_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_op1,
    output logic [DATA_WIDTH-1:0] instr_op2,
    output logic [1:0]            instr_size,
    output logic                  adv,
    output logic [STATE_W-1:0]    dbg_state
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            rdata_size;
    logic [ADDR_WIDTH-1:0] pc_plus1, pc_plus2;

    instr_len_decode u_len (
        .opcode (mem_rdata),
        .size   (rdata_size)
    );

    assign pc_plus1 = pc + ADDR_WIDTH'(1);
    assign pc_plus2 = pc + ADDR_WIDTH'(2);

    // Handshake: an instruction transfers on a cycle where instr_valid and
    // instr_ready are both high; valid never drops until that transfer (or a
    // flush), and the payload is held stable throughout.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        size_d      = size_q;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        adv         = 1'b1;

        if (flush) begin
            // The jump target is loaded into the PC on this edge; any read
            // already returning is dropped because S_OP never latches data.
            adv      = 1'b0;
            state_d  = S_OP;
            opcode_d = '0;
            op1_d    = '0;
            op2_d    = '0;
            size_d   = SZ1;
        end else begin
            case (state_q)
                S_OP: begin
                    mem_rd_en = 1'b1;
                    mem_addr  = pc;
                    state_d   = S_B1;
                end
                S_B1: begin
                    opcode_d = mem_rdata;
                    op1_d    = '0;
                    op2_d    = '0;
                    size_d   = rdata_size;
                    if (rdata_size == SZ1) begin
                        state_d = S_OUT;
                    end else begin
                        mem_rd_en = 1'b1;
                        mem_addr  = pc_plus1;
                        state_d   = S_B2;
                    end
                end
                S_B2: begin
                    op1_d = mem_rdata;
                    if (size_q == SZ3) begin
                        mem_rd_en = 1'b1;
                        mem_addr  = pc_plus2;
                        state_d   = S_B3;
                    end else begin
                        state_d = S_OUT;
                    end
                end
                S_B3: begin
                    op2_d   = mem_rdata;
                    state_d = S_OUT;
                end
                S_OUT: begin
                    instr_valid = 1'b1;
                    if (instr_ready) begin
                        adv     = 1'b0;
                        state_d = S_OP;
                    end
                end
                default: state_d = S_OP;
            endcase
        end

        // Reset state is S_OP, but no read or PC movement may escape while
        // rst_n is still low.
        if (!rst_n) begin
            mem_rd_en   = 1'b0;
            mem_addr    = '0;
            instr_valid = 1'b0;
            adv         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OP;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            size_q   <= SZ1;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            size_q   <= size_d;
        end
    end

    assign instr_opcode = opcode_q;
    assign instr_op1    = op1_q;
    assign instr_op2    = op2_q;
    assign instr_size   = size_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: byte memory and PC register models around the DUT,
// directed scenarios followed by randomized ready/flush traffic.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pc = 8'h00;
    logic [7:0] jump_addr = 8'h00;
    logic       flush = 1'b0;
    logic       instr_ready = 1'b0;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       instr_valid;
    logic [7:0] instr_opcode, instr_op1, instr_op2;
    logic [1:0] instr_size;
    logic       adv;
    logic [2:0] dbg_state;

    logic [7:0]  mem [256];
    logic [25:0] exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int n_accept = 0;
    int fetch_cyc = 0;
    int cur_size = 1;
    bit restart = 1'b1;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    instr_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .flush        (flush),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_op1    (instr_op1),
        .instr_op2    (instr_op2),
        .instr_size   (instr_size),
        .adv          (adv),
        .dbg_state    (dbg_state)
    );

    // Synchronous program memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction at pc is the length-field-selected
    // prefix of mem[pc..pc+2], with unused operand bytes zero.
    task automatic start_fetch();
        logic [7:0] a1, a2, b0, b1, b2;
        int n;
        a1 = pc + 8'd1;
        a2 = pc + 8'd2;
        b0 = mem[pc];
        b1 = mem[a1];
        b2 = mem[a2];
        n = (b0[7:6] == 2'b01) ? 2 : (b0[7:6] == 2'b10) ? 3 : 1;
        exp_q.push_back({2'(n), b0, (n >= 2) ? b1 : 8'h00, (n == 3) ? b2 : 8'h00});
        cur_size  = n;
        fetch_cyc = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    // A fetch reads one byte per cycle starting at pc, then holds valid from
    // cycle size+1 until accepted; the PC register moves only on accept/flush.
    always @(negedge clk) begin : monitor
        logic       exp_rd, exp_valid, take;
        logic [7:0] exp_addr;
        if (!rst_n) begin
            exp_q.delete();
            restart = 1'b1;
        end else begin
            if (restart) begin
                start_fetch();
                restart = 1'b0;
            end
            exp_rd    = !flush && (fetch_cyc < cur_size);
            exp_valid = !flush && (fetch_cyc > cur_size);
            take      = exp_valid && instr_ready;
            exp_addr  = pc + fetch_cyc[7:0];
            check("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, exp_rd});
            if (exp_rd) check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_addr});
            check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
            check("adv", {31'd0, adv}, {31'd0, !(flush || take)});
            if (exp_valid) begin
                if (exp_q.size() == 0)
                    check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                else
                    check("instr", {6'd0, instr_size, instr_opcode, instr_op1, instr_op2},
                          {6'd0, exp_q[0]});
            end
            if (flush) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                pc = jump_addr;
                start_fetch();
            end else if (take) begin
                void'(exp_q.pop_front());
                n_accept++;
                pc = pc + 8'(cur_size);
                start_fetch();
            end else begin
                fetch_cyc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush(input logic [7:0] tgt);
        flush     = 1'b1;
        jump_addr = tgt;
        cycle();
        flush = 1'b0;
    endtask

    task automatic wait_accept(input string tag);
        int base;
        base = n_accept;
        for (int i = 0; i < 60 && n_accept == base; i++) cycle();
        check(tag, {31'd0, n_accept > base}, 32'd1);
    endtask

    task automatic wait_until(input logic [7:0] tgt, input int cyc, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle();
            hit = (pc == tgt) && (fetch_cyc == cyc);
        end
        check(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_en"},  {31'd0, mem_rd_en},   32'd0);
        check({tag, "_addr"},   {24'd0, mem_addr},    32'd0);
        check({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
        check({tag, "_adv"},    {31'd0, adv},         32'd1);
        check({tag, "_opcode"}, {24'd0, instr_opcode}, 32'd0);
        check({tag, "_op1"},    {24'd0, instr_op1},   32'd0);
        check({tag, "_op2"},    {24'd0, instr_op2},   32'd0);
        check({tag, "_size"},   {30'd0, instr_size},  32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h05;
        mem[8'h10] = 8'h8A; mem[8'h11] = 8'h11; mem[8'h12] = 8'h22;
        mem[8'h20] = 8'h83; mem[8'h21] = 8'h5A; mem[8'h22] = 8'hC3;
        mem[8'h30] = 8'h07;
        mem[8'h40] = 8'h9C; mem[8'h41] = 8'h3E; mem[8'h42] = 8'h71;

        // Reset values, then a 1-byte instruction at pc 0.
        #12;
        check_reset_values("reset");
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_accept("accept_1byte");

        // 3-byte instruction at 10.
        do_flush(8'h10);
        wait_accept("accept_3byte");

        // 2-byte instruction wrapping from FF to 00.
        mem[8'hFF] = 8'h40;
        mem[8'h00] = 8'h99;
        do_flush(8'hFF);
        wait_accept("accept_wrap");

        // Decode stalls for 5 cycles while the instruction is presented.
        instr_ready = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                cycle();
                seen = (fetch_cyc > cur_size);
            end
            check("stall_reach_valid", {31'd0, seen}, 32'd1);
        end
        cycle(5);
        instr_ready = 1'b1;
        wait_accept("accept_after_stall");

        // Flush in S_B2 of a 3-byte fetch, redirect to a 1-byte instruction.
        do_flush(8'h20);
        wait_until(8'h20, 2, "reach_s_b2");
        do_flush(8'h30);
        wait_accept("accept_after_flush");

        // Asynchronous reset in S_B3, fetch restarts at the held pc.
        do_flush(8'h40);
        wait_until(8'h40, 3, "reach_s_b3");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        cycle(2);
        rst_n = 1'b1;
        wait_accept("accept_after_reset");

        // Randomized ready and flush traffic over random memory contents.
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                jump_addr = 8'($urandom);
                flush     = 1'b1;
            end else begin
                flush = 1'b0;
            end
            cycle();
        end
        flush       = 1'b0;
        instr_ready = 1'b1;
        wait_accept("accept_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
